// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the interrupt entry sequencer: state and source
// encodings, default vectors, status-register bit positions and helpers.
package cpu_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_DUMMY  = 3'd1,
        SEQ_PUSH_H = 3'd2,
        SEQ_PUSH_L = 3'd3,
        SEQ_PUSH_P = 3'd4,
        SEQ_VEC_LO = 3'd5,
        SEQ_VEC_HI = 3'd6,
        SEQ_DONE   = 3'd7
    } seq_state_e;

    typedef enum logic [1:0] {
        SRC_RESET = 2'd0,
        SRC_NMI   = 2'd1,
        SRC_IRQ   = 2'd2,
        SRC_BRK   = 2'd3
    } src_e;

    localparam logic [7:0]  DEF_STACK_PAGE   = 8'h01;
    localparam logic [15:0] DEF_NMI_VECTOR   = 16'hFFFA;
    localparam logic [15:0] DEF_RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VECTOR   = 16'hFFFE;

    localparam int PSR_I      = 2;
    localparam int PSR_B      = 4;
    localparam int PSR_UNUSED = 5;

    // Entry source priority: reset > NMI > IRQ; nothing pending means software BRK.
    function automatic src_e select_source(input logic rst, input logic nmi, input logic irq);
        if (rst)
            return SRC_RESET;
        else if (nmi)
            return SRC_NMI;
        else if (irq)
            return SRC_IRQ;
        else
            return SRC_BRK;
    endfunction

    // Stacked status: unused bit always set, B set only for a software break.
    function automatic logic [7:0] push_status(input logic [7:0] psr, input src_e src);
        logic [7:0] value;
        value             = psr;
        value[PSR_UNUSED] = 1'b1;
        value[PSR_B]      = (src == SRC_BRK);
        return value;
    endfunction

endpackage

// File: rtl/interrupt_sequencer.sv
// 6502 BRK/interrupt entry sequencer: pushes PC and status, fetches the vector.
// Optional macro INTERRUPT_SEQUENCER_NMI_HIJACK_EN lets a late NMI steal an IRQ/BRK vector.
module interrupt_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0]  STACK_PAGE   = DEF_STACK_PAGE,
    parameter logic [15:0] NMI_VECTOR   = DEF_NMI_VECTOR,
    parameter logic [15:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [15:0] IRQ_VECTOR   = DEF_IRQ_VECTOR
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enableFFs,
    input  logic        start,
    input  logic        resetRunning,
    input  logic        nmiRunning,
    input  logic        irqRunning,
    input  logic [15:0] retPc,
    input  logic [7:0]  psrIn,
    input  logic [7:0]  spIn,
    input  logic [7:0]  dataIn,
    output logic [15:0] address,
    output logic [7:0]  dataOut,
    output logic        writeEnable,
    output logic        busy,
    output logic        done,
    output logic [15:0] pcNext,
    output logic [7:0]  spNext,
    output logic        setIFlag
);

    localparam logic [2:0] ST_IDLE   = SEQ_IDLE;
    localparam logic [2:0] ST_DUMMY  = SEQ_DUMMY;
    localparam logic [2:0] ST_PUSH_H = SEQ_PUSH_H;
    localparam logic [2:0] ST_PUSH_L = SEQ_PUSH_L;
    localparam logic [2:0] ST_PUSH_P = SEQ_PUSH_P;
    localparam logic [2:0] ST_VEC_LO = SEQ_VEC_LO;
    localparam logic [2:0] ST_VEC_HI = SEQ_VEC_HI;
    localparam logic [2:0] ST_DONE   = SEQ_DONE;

    logic [2:0]  state_reg;
    src_e        src_reg;
    logic [7:0]  sp_copy_reg;
    logic [15:0] ret_pc_reg;
    logic [15:0] vec_reg;
    logic [15:0] pc_next_reg;
    logic [7:0]  sp_next_reg;
    logic [15:0] ret_addr;
    src_e        start_src;

    function automatic logic [15:0] vector_for(input src_e src);
        case (src)
            SRC_RESET: return RESET_VECTOR;
            SRC_NMI:   return NMI_VECTOR;
            default:   return IRQ_VECTOR;
        endcase
    endfunction

    assign start_src = select_source(resetRunning, nmiRunning, irqRunning);

    // BRK returns past its padding byte; hardware entries resume at the fetched opcode.
    assign ret_addr = (src_reg == SRC_BRK) ? ret_pc_reg + 16'd1 : ret_pc_reg;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= ST_IDLE;
            src_reg     <= SRC_RESET;
            sp_copy_reg <= 8'h00;
            ret_pc_reg  <= 16'h0000;
            vec_reg     <= 16'h0000;
            pc_next_reg <= 16'h0000;
            sp_next_reg <= 8'h00;
        end else if (enableFFs) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        src_reg     <= start_src;
                        sp_copy_reg <= spIn;
                        ret_pc_reg  <= retPc;
                        vec_reg     <= vector_for(start_src);
                        state_reg   <= ST_DUMMY;
                    end
                end
                ST_DUMMY:  state_reg <= ST_PUSH_H;
                ST_PUSH_H: begin
                    sp_copy_reg <= sp_copy_reg - 8'd1;
                    state_reg   <= ST_PUSH_L;
                end
                ST_PUSH_L: begin
                    sp_copy_reg <= sp_copy_reg - 8'd1;
                    state_reg   <= ST_PUSH_P;
                end
                ST_PUSH_P: begin
                    sp_copy_reg <= sp_copy_reg - 8'd1;
                    state_reg   <= ST_VEC_LO;
                end
                ST_VEC_LO: begin
                    pc_next_reg[7:0] <= dataIn;
                    state_reg        <= ST_VEC_HI;
                end
                ST_VEC_HI: begin
                    pc_next_reg[15:8] <= dataIn;
                    sp_next_reg       <= sp_copy_reg;
                    state_reg         <= ST_DONE;
                end
                default:   state_reg <= ST_IDLE;
            endcase
`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
            // An NMI arriving before the vector fetch redirects an IRQ/BRK entry.
            if (nmiRunning && (src_reg == SRC_IRQ || src_reg == SRC_BRK) &&
                (state_reg inside {ST_DUMMY, ST_PUSH_H, ST_PUSH_L, ST_PUSH_P}))
                vec_reg <= NMI_VECTOR;
`endif
        end
    end

    always_comb begin
        address     = 16'h0000;
        dataOut     = 8'h00;
        writeEnable = 1'b0;
        busy        = (state_reg != ST_IDLE);
        done        = (state_reg == ST_DONE);
        setIFlag    = (state_reg == ST_DONE);
        case (state_reg)
            ST_DUMMY: address = ret_pc_reg;
            ST_PUSH_H: begin
                address     = {STACK_PAGE, sp_copy_reg};
                dataOut     = ret_addr[15:8];
                writeEnable = (src_reg != SRC_RESET);
            end
            ST_PUSH_L: begin
                address     = {STACK_PAGE, sp_copy_reg};
                dataOut     = ret_addr[7:0];
                writeEnable = (src_reg != SRC_RESET);
            end
            ST_PUSH_P: begin
                address     = {STACK_PAGE, sp_copy_reg};
                dataOut     = push_status(psrIn, src_reg);
                writeEnable = (src_reg != SRC_RESET);
            end
            ST_VEC_LO: address = vec_reg;
            ST_VEC_HI: address = vec_reg + 16'd1;
            default: ;
        endcase
    end

    assign pcNext = pc_next_reg;
    assign spNext = sp_next_reg;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized bench for interrupt_sequencer against a step-indexed bus-trace model.
// Honours INTERRUPT_SEQUENCER_NMI_HIJACK_EN when deciding the expected vector.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        enableFFs = 1'b0;
    logic        start = 1'b0;
    logic        resetRunning = 1'b0;
    logic        nmiRunning = 1'b0;
    logic        irqRunning = 1'b0;
    logic [15:0] retPc = 16'h0;
    logic [7:0]  psrIn = 8'h0;
    logic [7:0]  spIn = 8'h0;
    logic [7:0]  dataIn = 8'h0;
    logic [15:0] address;
    logic [7:0]  dataOut;
    logic        writeEnable;
    logic        busy;
    logic        done;
    logic [15:0] pcNext;
    logic [7:0]  spNext;
    logic        setIFlag;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
    localparam bit HIJACK = 1'b1;
`else
    localparam bit HIJACK = 1'b0;
`endif

    interrupt_sequencer dut (
        .clk(clk), .nrst(nrst), .enableFFs(enableFFs), .start(start),
        .resetRunning(resetRunning), .nmiRunning(nmiRunning), .irqRunning(irqRunning),
        .retPc(retPc), .psrIn(psrIn), .spIn(spIn), .dataIn(dataIn),
        .address(address), .dataOut(dataOut), .writeEnable(writeEnable),
        .busy(busy), .done(done), .pcNext(pcNext), .spNext(spNext), .setIFlag(setIFlag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // src: 0=reset 1=NMI 2=IRQ 3=BRK. Steps: 1..7 = the seven sequence cycles, 8 = back in idle.
    task automatic run_seq(input int src, input logic [15:0] pc, input logic [7:0] sp,
                           input logic [7:0] psr, input logic [7:0] vlo, input logic [7:0] vhi,
                           input int stall_pct, input int forced_step, input bit nmi_late,
                           input bit poke_start);
        logic [15:0] ret, vec, exp_addr;
        logic [7:0]  pushed [3];
        logic [7:0]  psr_b, exp_data, slot;
        logic [3:0]  exp_flags;
        int step, stalls, edges, forced;
        bit en;
        ret   = (src == 3) ? pc + 16'd1 : pc;
        psr_b = psr | 8'h20;
        psr_b = (src == 3) ? (psr_b | 8'h10) : (psr_b & 8'hEF);
        pushed[0] = ret[15:8];
        pushed[1] = ret[7:0];
        pushed[2] = psr_b;
        vec = (src == 0) ? 16'hFFFC : (src == 1) ? 16'hFFFA : 16'hFFFE;
        if (HIJACK && nmi_late && src >= 2)
            vec = 16'hFFFA;
        resetRunning = (src == 0);
        nmiRunning   = (src == 1) || (src == 0 && $urandom_range(1) == 1);
        irqRunning   = (src == 2) || (src < 2 && $urandom_range(1) == 1);
        retPc = pc; spIn = sp; psrIn = psr;
        dataIn = 8'($urandom);
        start = 1'b1; enableFFs = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        step = 1; stalls = 0; edges = 0; forced = 0;
        while (step <= 8 && edges < 100) begin
            exp_addr = 16'h0; exp_data = 8'h0;
            exp_flags = 4'b0100;
            case (step)
                1: exp_addr = pc;
                2, 3, 4: begin
                    slot      = sp - 8'(step - 2);
                    exp_addr  = {8'h01, slot};
                    exp_data  = pushed[step - 2];
                    exp_flags = {(src != 0), 3'b100};
                end
                5: exp_addr = vec;
                6: exp_addr = vec + 16'd1;
                7: exp_flags = 4'b0111;
                default: exp_flags = 4'b0000;
            endcase
            check_eq($sformatf("addr s%0d", step), {16'h0, address}, {16'h0, exp_addr});
            check_eq($sformatf("we/busy/done/seti s%0d", step),
                     {28'h0, writeEnable, busy, done, setIFlag}, {28'h0, exp_flags});
            if (step >= 2 && step <= 4 && src != 0)
                check_eq($sformatf("dout s%0d", step), {24'h0, dataOut}, {24'h0, exp_data});
            if (step >= 7) begin
                check_eq("pcNext", {16'h0, pcNext}, {16'h0, vhi, vlo});
                check_eq("spNext", {24'h0, spNext}, {24'h0, sp - 8'd3});
            end
            if (step == 8) break;
            if (step == forced_step && forced < 3) begin
                en = 1'b0;
                forced++;
            end else begin
                en = ($urandom_range(99) >= stall_pct);
            end
            if (!en) stalls++;
            enableFFs = en;
            start = poke_start && ($urandom_range(1) == 1);
            dataIn = (step == 5) ? vlo : (step == 6) ? vhi : 8'($urandom);
            if (nmi_late && step == 2) nmiRunning = 1'b1;
            @(posedge clk); #1;
            edges++;
            if (en) step++;
        end
        start = 1'b0; enableFFs = 1'b1;
        resetRunning = 1'b0; nmiRunning = 1'b0; irqRunning = 1'b0;
        check_eq("reached idle", step, 8);
        check_eq("latency", edges, 7 + stalls);
        $display("txn src=%0d pc=%04h sp=%02h psr=%02h vec=%04h stalls=%0d -> pcNext=%04h spNext=%02h",
                 src, pc, sp, psr, vec, stalls, pcNext, spNext);
    endtask

    initial begin
        #12;
        check_eq("reset addr", {16'h0, address}, 32'h0);
        check_eq("reset flags", {28'h0, writeEnable, busy, done, setIFlag}, 32'h0);
        check_eq("reset pcNext/spNext", {8'h0, pcNext, spNext}, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;

        run_seq(3, 16'h1234, 8'hFD, 8'h20, 8'h00, 8'h80, 0, 0, 1'b0, 1'b0);
        run_seq(2, 16'h1234, 8'hFD, 8'h20, 8'h11, 8'h22, 0, 0, 1'b0, 1'b0);
        run_seq(1, 16'h4000, 8'h01, 8'h04, 8'h33, 8'h44, 0, 0, 1'b0, 1'b0);
        run_seq(0, 16'hABCD, 8'h00, 8'hC3, 8'h55, 8'h66, 0, 0, 1'b0, 1'b0);
        run_seq(3, 16'hFFFF, 8'h80, 8'hFF, 8'h77, 8'h88, 0, 0, 1'b0, 1'b0);
        run_seq(2, 16'h2222, 8'h40, 8'h01, 8'h99, 8'hAA, 0, 3, 1'b0, 1'b1);
        run_seq(2, 16'h3456, 8'hF0, 8'h00, 8'hBB, 8'hCC, 0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++)
            run_seq(int'($urandom_range(3)), 16'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 25, 0, 1'b0, 1'b1);

        // Asynchronous reset landing in PUSH_P.
        irqRunning = 1'b1; retPc = 16'h5555; spIn = 8'hFD; psrIn = 8'h00;
        start = 1'b1; enableFFs = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("pre-reset we/busy", {30'h0, writeEnable, busy}, 32'h3);
        #2 nrst = 1'b0;
        #1;
        check_eq("async reset addr", {16'h0, address}, 32'h0);
        check_eq("async reset flags", {28'h0, writeEnable, busy, done, setIFlag}, 32'h0);
        check_eq("async reset pcNext/spNext", {8'h0, pcNext, spNext}, 32'h0);
        #2 nrst = 1'b1;
        irqRunning = 1'b0;
        @(posedge clk); #1;
        check_eq("post-reset idle", {31'h0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Executes the 6502 BRK/interrupt entry micro-sequence after the instruction loader has forced a break opcode into the instruction register. Handles these entry sources:
- reset
- NMI
- IRQ
- software BRK
For each it pushes PCH, PCL and the status byte to the stack page, fetches the matching vector, and hands the new PC and SP back to the datapath. It sits between the instruction loader/interrupt injector and the register file/external bus, as the consumer of the injected BRK.

Parameters:
STACK_PAGE, 8'h01, high address byte for stack accesses
NMI_VECTOR, 16'hFFFA, NMI vector low-byte address
RESET_VECTOR, 16'hFFFC, reset vector low-byte address
IRQ_VECTOR, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
enableFFs  input  1  clock enable; state and captures advance only when high
start  input  1  break opcode just loaded; sampled only in IDLE
resetRunning  input  1  entry is a reset
nmiRunning  input  1  entry is an NMI
irqRunning  input  1  entry is an IRQ (none high = software BRK)
retPc  input  16  PC at the opcode fetch that loaded the break
psrIn  input  8  current status register
spIn  input  8  current stack pointer
dataIn  input  8  external data bus read value
address  output  16  external bus address
dataOut  output  8  external bus write data
writeEnable  output  1  external bus write strobe
busy  output  1  sequence in progress
done  output  1  one-cycle pulse: pcNext/spNext valid
pcNext  output  16  vector fetched
spNext  output  8  stack pointer after three decrements
setIFlag  output  1  set PSR I flag (asserted with done)

Behaviour:
- Reset (nrst low, asynchronous): state IDLE; all outputs 0; internal source, SP copy and vector registers cleared.
- FSM states, advancing one per enabled clock: IDLE -> DUMMY -> PUSH_H -> PUSH_L -> PUSH_P -> VEC_LO -> VEC_HI -> DONE -> IDLE.
- With enableFFs low, state and registers hold and outputs are held steady.
- Start and source capture:
  - start in IDLE captures the source with priority reset > NMI > IRQ > BRK, plus spIn and retPc.
  - start outside IDLE is ignored.
- Pushed return address: BRK pushes retPc+1 (16-bit wrap, skips padding byte); IRQ/NMI/reset use retPc.
- DUMMY: address = retPc; read; no write.
- PUSH_H / PUSH_L / PUSH_P:
  - address = {STACK_PAGE, spCopy}.
  - dataOut = return address high / return address low / status.
  - Status byte = psrIn with bit5=1 and bit4 (B) = 1 for BRK, 0 otherwise.
  - spCopy decrements after each state, 8-bit wrap (00 -> FF).
- Reset source: the three push states are reads (writeEnable=0) but still decrement spCopy.
- writeEnable is high only in push states for non-reset sources.
- VEC_LO: address = selected vector; dataIn captured into pcNext[7:0] at the enabled clock edge.
- VEC_HI: address = selected vector+1; dataIn captured into pcNext[15:8].
- DONE: done=1, setIFlag=1, spNext=spCopy; address=0, writeEnable=0.
- busy is 1 in every state except IDLE.
- Total latency from start edge to done: 7 enabled cycles.
- Vector select: reset -> RESET_VECTOR; NMI -> NMI_VECTOR; IRQ/BRK -> IRQ_VECTOR.
- pcNext and spNext hold their values until the next start.

Optional Feature:
Macro INTERRUPT_SEQUENCER_NMI_HIJACK_EN.
- Defined: if nmiRunning is high in any state from DUMMY through PUSH_P during an IRQ or BRK sequence, the vector switches to NMI_VECTOR. The pushed status byte is unchanged (B stays as captured).
- Undefined: the vector is fixed at start capture.

Decomposition:
- Shared package cpu_pkg holds:
  - sequencer state enum
  - source enum (SRC_RESET, SRC_NMI, SRC_IRQ, SRC_BRK)
  - default vector constants
  - status bit index constants (B=4, unused=5, I=2)
- No sub-module; a single FSM with datapath registers.

Test Plan:
- BRK, retPc=1234, spIn=FD, psrIn=20, dataIn 00 then 80 at the vector fetches -> writes 01FD=12, 01FC=35, 01FB=30; reads FFFE/FFFF; done on cycle 7; pcNext=8000; spNext=FA; setIFlag=1.
- IRQ, retPc=1234, spIn=FD, psrIn=20 -> pushes 12, 34, 20 (B=0); vector FFFE.
- NMI, spIn=01 -> pushes at 0101, 0100, 01FF; spNext=FE; vector FFFA.
- Reset, spIn=00 -> no writeEnable at any cycle; reads at 0100, 01FF, 01FE; vector FFFC/FFFD; spNext=FD.
- enableFFs low for 3 cycles during PUSH_L -> state, address and dataOut hold; done arrives 3 cycles late; start pulsed mid-sequence is ignored.
- nrst asserted in PUSH_P -> immediately IDLE, writeEnable=0, busy=0; with the macro defined, NMI raised during an IRQ's PUSH_H -> vector fetch at FFFA.
